// File: rtl/md5_stream_ctrl.sv
// Packs a 32-bit little-endian message stream into padded 512-bit MD5 blocks and sequences the hash core.
// Build option MD5_CTRL_BYTESWAP_EN: byte-reverse each input word before storage.
//   state | meaning
//   IDLE  | waiting for the first word of a message
//   FILL  | collecting message words into the block
//   PAD   | writing 0x80 / zero padding words
//   LEN   | writing the bit length into words 14-15
//   START | waiting for core_ready, then one init/next pulse
//   WAIT  | core hashing the block
//   DONE  | digest captured, digest_valid pulse
module md5_stream_ctrl #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_digest,
  output logic [127:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_LEN, S_START, S_WAIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wc_q, wc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [0:15][31:0] blk_q, blk_d;
  logic              first_q, first_d;
  logic              pad80_q, pad80_d;
  logic              tail_q, tail_d;
  logic              final_q, final_d;
  logic              skip_q, skip_d;
  logic [127:0]      digest_q, digest_d;

  logic [31:0] word_in, word_pad;
  logic [2:0]  nbytes;
  logic [63:0] len_ext;

`ifdef MD5_CTRL_BYTESWAP_EN
  assign word_in = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign word_in = in_data;
`endif

  assign nbytes  = (in_last && in_bytes != 2'd0) ? {1'b0, in_bytes} : 3'd4;
  assign len_ext = 64'(len_q);

  // Keep the valid bytes of the word and drop the 0x80 marker into the first free byte.
  always_comb begin
    word_pad = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes) word_pad[8*k +: 8] = word_in[8*k +: 8];
      else if (3'(k) == nbytes) word_pad[8*k +: 8] = 8'h80;
    end
  end

  always_comb begin
    state_d      = state_q;
    wc_d         = wc_q;
    len_d        = len_q;
    blk_d        = blk_q;
    first_d      = first_q;
    pad80_d      = pad80_q;
    tail_d       = tail_q;
    final_d      = final_q;
    skip_d       = skip_q;
    digest_d     = digest_q;
    in_ready     = 1'b0;
    core_init    = 1'b0;
    core_next    = 1'b0;
    digest_valid = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE, S_FILL: begin
          in_ready = 1'b1;
          if (in_valid) begin
            blk_d[wc_q] = word_pad;
            wc_d        = wc_q + 4'd1;
            len_d       = len_q + LEN_W'({nbytes, 3'b000});
            state_d     = S_FILL;
            if (state_q == S_IDLE) first_d = 1'b1;
            if (in_last) begin
              pad80_d = (nbytes == 3'd4);
              tail_d  = 1'b1;
              state_d = (wc_q == 4'd15) ? S_START : S_PAD;
            end else if (wc_q == 4'd15) begin
              state_d = S_START;
            end
          end
        end
        S_PAD: begin
          if (wc_q == 4'd14 && !pad80_q) begin
            state_d = S_LEN;
          end else begin
            blk_d[wc_q] = pad80_q ? 32'h0000_0080 : 32'h0;
            pad80_d     = 1'b0;
            wc_d        = wc_q + 4'd1;
            if (wc_q == 4'd15) state_d = S_START;
          end
        end
        S_LEN: begin
          blk_d[14] = len_ext[31:0];
          blk_d[15] = len_ext[63:32];
          final_d   = 1'b1;
          state_d   = S_START;
        end
        S_START: begin
          if (core_ready) begin
            core_init = first_q;
            core_next = !first_q;
            first_d   = 1'b0;
            skip_d    = 1'b1;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else if (core_ready) begin
            wc_d = 4'd0;
            if (final_q) begin
              digest_d = core_digest;
              state_d  = S_DONE;
            end else begin
              state_d = tail_q ? S_PAD : S_FILL;
            end
          end
        end
        S_DONE: begin
          digest_valid = 1'b1;
          wc_d         = 4'd0;
          len_d        = '0;
          pad80_d      = 1'b0;
          tail_d       = 1'b0;
          final_d      = 1'b0;
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wc_q     <= '0;
      len_q    <= '0;
      blk_q    <= '0;
      first_q  <= 1'b0;
      pad80_q  <= 1'b0;
      tail_q   <= 1'b0;
      final_q  <= 1'b0;
      skip_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      wc_q     <= wc_d;
      len_q    <= len_d;
      blk_q    <= blk_d;
      first_q  <= first_d;
      pad80_q  <= pad80_d;
      tail_q   <= tail_d;
      final_q  <= final_d;
      skip_q   <= skip_d;
      digest_q <= digest_d;
    end
  end

  assign core_block = blk_q;
  assign digest     = digest_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_md5_stream_ctrl.sv
// Testbench for md5_stream_ctrl: behavioural MD5 core plus a byte-level padding reference model.
module tb_md5_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic         core_ready = 1'b1;
  logic [127:0] core_digest;
  logic [127:0] digest;
  logic         digest_valid;
  logic         busy;

  md5_stream_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .core_digest(core_digest),
    .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] MD5_IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] kt [64];
  int sh_tab [0:3][0:3] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  logic [127:0] md_st = MD5_IV;
  int           core_lat = 2;
  int           busy_cnt = 0;
  int           pulse_cnt = 0;
  logic [511:0] blk_log [$];
  logic         kind_log [$];
  byte unsigned msg_q [$];
  logic [511:0] exp_blk [$];
  logic [127:0] exp_dg;
  logic [127:0] got_dg;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [127:0] to_digest(input logic [127:0] st);
    return {bswap(st[127:96]), bswap(st[95:64]), bswap(st[63:32]), bswap(st[31:0])};
  endfunction

  function automatic logic [31:0] word_of(input logic [511:0] blk, input int i);
    return blk[511-32*i -: 32];
  endfunction

  function automatic logic [127:0] md5_blk(input logic [127:0] st, input logic [511:0] blk);
    logic [31:0] a, b, c, d, f;
    int g, s;
    a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      f = f + a + kt[i] + word_of(blk, g);
      s = sh_tab[i / 16][i % 4];
      a = d; d = c; c = b;
      b = b + ((f << s) | (f >> (32 - s)));
    end
    return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
  endfunction

  assign core_digest = to_digest(md_st);

  // Hash core stand-in: hashes on each pulse and stays busy for core_lat cycles.
  always @(posedge clk) begin
    if (reset) begin
      core_ready <= 1'b1;
      busy_cnt   <= 0;
    end else if (core_init || core_next) begin
      blk_log.push_back(core_block);
      kind_log.push_back(core_init);
      pulse_cnt  <= pulse_cnt + 1;
      md_st      <= md5_blk(core_init ? MD5_IV : md_st, core_block);
      core_ready <= 1'b0;
      busy_cnt   <= core_lat;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) core_ready <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] logged(input int i);
    if (i < blk_log.size()) return blk_log[i];
    return 'x;
  endfunction

  function automatic logic kind_of(input int i);
    if (i < kind_log.size()) return kind_log[i];
    return 1'bx;
  endfunction

  task automatic set_rand(input int n);
    msg_q.delete();
    repeat (n) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: standard MD5 padding of the byte string, then split into 64-byte blocks.
  task automatic build_exp();
    byte unsigned p [$];
    logic [63:0]  lb;
    logic [511:0] blk;
    logic [127:0] st;
    p  = msg_q;
    lb = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 0; k < 8; k++) p.push_back(lb[8*k +: 8]);
    exp_blk.delete();
    st = MD5_IV;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int i = 0; i < 16; i++)
        blk[511-32*i -: 32] = {p[64*b+4*i+3], p[64*b+4*i+2], p[64*b+4*i+1], p[64*b+4*i]};
      exp_blk.push_back(blk);
      st = md5_blk(st, blk);
    end
    exp_dg = to_digest(st);
  endtask

  task automatic send_words(input int gap_mode, input bit zero_fill);
    int n, nw, idle, idx, guard;
    logic [31:0] w32;
    bit to;
    n  = msg_q.size();
    nw = (n + 3) / 4;
    to = 1'b0;
    for (int w = 0; w < nw; w++) begin
      idle = (gap_mode == 1) ? ((w > 0) ? 1 : 0) :
             (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (idle) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
        idx = 4 * w + k;
        w32[8*k +: 8] = (idx < n) ? msg_q[idx] : (zero_fill ? 8'h00 : 8'($urandom_range(0, 255)));
      end
`ifdef MD5_CTRL_BYTESWAP_EN
      in_data = bswap(w32);
`else
      in_data = w32;
`endif
      in_valid = 1'b1;
      in_last  = (w == nw - 1);
      in_bytes = in_last ? 2'(n % 4) : 2'($urandom_range(0, 3));
      guard = 0;
      while (!in_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) to = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("accept_timeout", 512'(to), 512'(0));
  endtask

  task automatic wait_done(output logic [127:0] dg);
    int guard;
    guard = 0;
    while (!digest_valid && guard < 3000) begin
      if (!core_ready && blk_log.size() > 0)
        chk("block_stable", core_block, blk_log[blk_log.size()-1]);
      @(negedge clk);
      guard++;
    end
    chk("done_timeout", 512'(guard >= 3000), 512'(0));
    dg = digest;
    @(negedge clk);
    chk("dv_one_cycle", 512'(digest_valid), 512'(0));
    chk("idle_after_done", 512'(busy), 512'(0));
    chk("ready_after_done", 512'(in_ready), 512'(1));
    chk("digest_hold", 512'(digest), 512'(dg));
  endtask

  task automatic run_msg(input int gap_mode, input int lat, input bit zero_fill);
    core_lat = lat;
    blk_log.delete();
    kind_log.delete();
    build_exp();
    send_words(gap_mode, zero_fill);
    wait_done(got_dg);
    chk($sformatf("digest_len%0d", msg_q.size()), 512'(got_dg), 512'(exp_dg));
    chk($sformatf("nblocks_len%0d", msg_q.size()), 512'(blk_log.size()), 512'(exp_blk.size()));
    for (int i = 0; i < exp_blk.size(); i++) begin
      chk($sformatf("block%0d_len%0d", i, msg_q.size()), logged(i), exp_blk[i]);
      chk($sformatf("kind%0d_len%0d", i, msg_q.size()), 512'(kind_of(i)), 512'(i == 0));
    end
  endtask

  initial begin
    int pulse0, guard, dv_seen;
    int lens [9] = '{55, 56, 63, 64, 1, 2, 3, 119, 120};
    for (int i = 0; i < 64; i++) begin
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kt[i] = 32'(longint'($floor(r * 4294967296.0)));
    end
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_core_init", 512'(core_init), 512'(0));
    chk("rst_core_next", 512'(core_next), 512'(0));
    chk("rst_digest_valid", 512'(digest_valid), 512'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 512'(in_ready), 512'(1));
    chk("post_rst_busy", 512'(busy), 512'(0));
    chk("post_rst_block", core_block, 512'(0));
    chk("post_rst_digest", 512'(digest), 512'(0));

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(0, 3, 1'b1);
    chk("abc_digest", 512'(got_dg), 512'(128'h900150983cd24fb0d6963f7d28e17f72));
    chk("abc_w0", 512'(word_of(logged(0), 0)), 512'(32'h80636261));
    chk("abc_w14", 512'(word_of(logged(0), 14)), 512'(32'h18));

    set_rand(4);
    run_msg(0, 2, 1'b0);
    chk("four_w1", 512'(word_of(logged(0), 1)), 512'(32'h80));
    chk("four_w14", 512'(word_of(logged(0), 14)), 512'(32'h20));

    set_rand(60);
    run_msg(0, 2, 1'b0);
    chk("sixty_b1_w14", 512'(word_of(logged(1), 14)), 512'(32'h1E0));
    chk("sixty_b1_w0", 512'(word_of(logged(1), 0)), 512'(0));

    foreach (lens[i]) begin
      set_rand(lens[i]);
      run_msg(2, int'($urandom_range(1, 4)), 1'b0);
    end

    set_rand(9);
    run_msg(0, 20, 1'b0);

    msg_q = '{8'h61, 8'h62, 8'h63};
    core_lat = 30;
    pulse0 = pulse_cnt;
    send_words(0, 1'b1);
    guard = 0;
    while (pulse_cnt == pulse0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_pulse_timeout", 512'(guard >= 200), 512'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wait_busy", 512'(busy), 512'(0));
    chk("rst_wait_dv", 512'(digest_valid), 512'(0));
    reset = 1'b0;
    dv_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (digest_valid) dv_seen++;
    end
    chk("rst_wait_no_dv", 512'(dv_seen), 512'(0));
    run_msg(0, 2, 1'b1);
    chk("abc_after_rst", 512'(got_dg), 512'(128'h900150983cd24fb0d6963f7d28e17f72));

    set_rand(160);
    run_msg(1, 2, 1'b0);
    chk("forty_w14", 512'(word_of(logged(2), 14)), 512'(32'h500));

    repeat (6) begin
      set_rand(int'($urandom_range(1, 200)));
      run_msg(2, int'($urandom_range(1, 5)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md5_stream_ctrl.md
MD5_STREAM_CTRL -- requirements
Module: md5_stream_ctrl

Interface
REQ-001 Parameter LEN_W, default 64, width of the message bit-length counter (legal 32..64); upper unused length bits drive 0.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  message word offered.
REQ-005 in_ready  output  1  controller accepts word when in_valid&in_ready.
REQ-006 in_data  input  32  message word; message byte k of word = in_data[8k+7:8k].
REQ-007 in_last  input  1  word is final word of message.
REQ-008 in_bytes  input  2  valid bytes in final word (0 means 4); ignored unless in_last.
REQ-009 core_init, core_next  output  1 each  single-cycle start pulses to hash core.
REQ-010 core_block  output  512  block to core; word 0 at [511:480], word 15 at [31:0].
REQ-011 core_ready  input  1  hash core idle.
REQ-012 core_digest  input  128  hash core digest.
REQ-013 digest  output  128  registered copy of core_digest at completion.
REQ-014 digest_valid  output  1  one-cycle pulse, digest valid.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, FILL, PAD, LEN, START, WAIT, DONE.
REQ-017 IDLE: in_ready=1; first accepted word goes to word 0 and enters FILL; word counter wc (0..15) and bit length count it.
REQ-018 FILL: in_ready=1 while wc<16; each accepted word writes block word wc, wc+1, length += 32 (or 8*in_bytes on last).
REQ-019 wc reaching 16 without in_last -> START (full block), in_ready=0 until block hashed, then FILL with wc=0.
REQ-020 On in_last: bytes beyond in_bytes in that word cleared; 0x80 placed in first free byte (next word if last word full); -> PAD.
REQ-021 PAD: zero words up to word 13; if 0x80 landed at or beyond word 14 (message mod 64 >= 56 bytes), zero-fill to 15, START, then a second all-zero block with length.
REQ-022 LEN: word 14 = length[31:0], word 15 = length[63:32]; length in bits, wraps modulo 2^LEN_W.
REQ-023 START: waits core_ready=1, then pulses core_init for first block of message, core_next for later blocks; exactly one cycle.
REQ-024 WAIT: core_ready ignored the cycle after pulse, then waits core_ready=1; core_block held stable from START until WAIT exits.
REQ-025 Final block completion -> DONE: digest <= core_digest, digest_valid=1 one cycle, -> IDLE next cycle.
REQ-026 Empty message (in_last with in_bytes=1..3 invalid) not supported via stream; zero-length handled by in_valid&in_last&in_bytes with no data not defined -- bench uses 1+ byte messages except REQ-036.
REQ-027 in_ready=0 in PAD, LEN, START, WAIT, DONE; in_valid there is held off, no word dropped.
REQ-028 Back-to-back messages: new message may start in cycle following DONE.
REQ-029 Latency last word accept -> core pulse: at most 17 cycles plus core_ready wait.

Reset
REQ-030 reset forces IDLE next edge regardless of state, including mid-WAIT; in-flight message discarded.
REQ-031 Reset values: in_ready=0 during reset cycle then 1, core_init=0, core_next=0, core_block=0, digest=0, digest_valid=0, busy=0, wc=0, length=0.

Configuration
REQ-032 Macro MD5_CTRL_BYTESWAP_EN defined: in_data byte-reversed ({[7:0],[15:8],[23:16],[31:24]}) before storage, in_bytes counts from in_data[31:24].
REQ-033 Macro undefined: in_data stored unchanged; all other behaviour identical.
REQ-034 Length and padding words never byte-swapped.

Verification
REQ-035 "abc" (in_data=0x00636261, in_bytes=3, in_last) -> one core_init, block word0=0x80636261, words1-13=0, word14=0x00000018, word15=0; digest=900150983cd24fb0d6963f7d28e17f72 with reference core.
REQ-036 Single word in_bytes=0 (4 bytes) -> word1=0x00000080, word14=0x00000020.
REQ-037 14 full words then in_last word 15 (60 bytes) -> two blocks: core_init then core_next, second block words0-13=0, word14=0x000001E0.
REQ-038 Core_ready held low 20 cycles after pulse -> no second pulse, core_block unchanged, digest_valid only after core_ready returns.
REQ-039 reset asserted during WAIT -> next cycle busy=0, no digest_valid, following "abc" message hashed correctly.
REQ-040 in_valid toggling every other cycle, 40-word message -> three blocks, init/next/next, length word14=0x00000500.
